// File: rtl/pwc_pkg.sv
// pwc_pkg: shared widths, saturation limit, trailer word and TX state encoding for pulse_width_capture.
package pwc_pkg;
    localparam int WIDTH_BITS = 16;
    localparam logic [WIDTH_BITS-1:0] WIDTH_MAX = 16'hFFFE;
    localparam logic [WIDTH_BITS-1:0] TRAILER_WORD = 16'hFFFF;
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND_HI  = 3'd1,
        SEND_LO  = 3'd2,
        TRL_HI   = 3'd3,
        TRL_LO   = 3'd4,
        FINISHED = 3'd5
    } tx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO; head word is visible on rd_data with no read latency.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr, rd_ptr;
    logic [ADDR_BITS:0] count;

    assign full = count == (ADDR_BITS+1)'(DEPTH);
    assign empty = count == '0;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (ADDR_BITS+1)'(wr_en) - (ADDR_BITS+1)'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/pulse_width_capture.sv
// pulse_width_capture: measures pulse high times, buffers them, and streams them big-endian
// to a byte sink, closing the run with a one-time 0xFFFF trailer.
module pulse_width_capture
    import pwc_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_BITS = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        pulse_in,
    input  logic        done_in,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] pulse_count,
    output logic        overflow
);
    logic r_prev, done_seen, full, empty, push, wr_en, pop, valid_n;
    logic [WIDTH_BITS-1:0] cnt, shadow, shadow_n, rd_data;
    logic [7:0] data_n;
    tx_state_t state, state_n;

    // A zero count at a falling edge means the pulse was discarded by enable
    assign push = enable && r_prev && !pulse_in && cnt != '0;
    assign wr_en = push && (!full || pop);

    sync_fifo #(.WIDTH(WIDTH_BITS), .DEPTH(FIFO_DEPTH), .ADDR_BITS(ADDR_BITS)) u_fifo (
        .clk(clk),
        .reset(reset),
        .wr_en(wr_en),
        .rd_en(pop),
        .wr_data(cnt),
        .full(full),
        .empty(empty),
        .rd_data(rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev <= 1'b0;
            done_seen <= 1'b0;
            cnt <= '0;
            pulse_count <= '0;
            overflow <= 1'b0;
        end else begin
            r_prev <= pulse_in;
            done_seen <= done_seen || done_in;
            cnt <= !enable ? '0 : !pulse_in ? '0 : !r_prev ? 16'd1 : cnt == WIDTH_MAX ? cnt : cnt + 16'd1;
            if (wr_en && pulse_count != 16'hFFFF) pulse_count <= pulse_count + 16'd1;
            if (push && !wr_en) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            tx_data <= '0;
            tx_valid <= 1'b0;
            shadow <= '0;
        end else begin
            state <= state_n;
            tx_data <= data_n;
            tx_valid <= valid_n;
            shadow <= shadow_n;
        end
    end

    always_comb begin
        state_n = state;
        data_n = tx_data;
        valid_n = tx_valid;
        shadow_n = shadow;
        pop = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    shadow_n = rd_data;
                    data_n = rd_data[15:8];
                    valid_n = 1'b1;
                    state_n = SEND_HI;
                end else if (done_seen && !pulse_in && cnt == '0) begin
                    data_n = TRAILER_WORD[15:8];
                    valid_n = 1'b1;
                    state_n = TRL_HI;
                end
            end
            SEND_HI: if (tx_ready) begin
                data_n = shadow[7:0];
                state_n = SEND_LO;
            end
            TRL_HI: if (tx_ready) begin
                data_n = TRAILER_WORD[7:0];
                state_n = TRL_LO;
            end
            SEND_LO: if (tx_ready) begin
                valid_n = 1'b0;
                state_n = IDLE;
            end
            TRL_LO: if (tx_ready) begin
                valid_n = 1'b0;
                state_n = FINISHED;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_pulse_width_capture.sv
// tb_pulse_width_capture: directed scenario tasks for pulse_width_capture with hand-computed bytes.
module tb_pulse_width_capture;
    logic clk = 1'b0;
    logic reset, enable, pulse_in, done_in, tx_ready, tx_valid, overflow;
    logic [7:0] tx_data;
    logic [15:0] pulse_count;
    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] rx[$];
    logic hold = 1'b0;
    logic [7:0] hold_data = 8'h00;

    always #5 clk = ~clk;

    pulse_width_capture #(.FIFO_DEPTH(8), .ADDR_BITS(3)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .pulse_in(pulse_in),
        .done_in(done_in),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .pulse_count(pulse_count),
        .overflow(overflow)
    );

    // Byte collector plus hold-stability monitor on pre-edge values
    always @(posedge clk) begin
        if (!reset) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                n_cmp++;
                if (tx_valid !== 1'b1 || tx_data !== hold_data) begin
                    n_err++;
                    $display("FAIL hold_stable: valid=%b data=%h, required valid=1 data=%h", tx_valid, tx_data, hold_data);
                end
            end
            if (tx_valid && tx_ready) rx.push_back(tx_data);
            hold = tx_valid && !tx_ready;
            hold_data = tx_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int n);
        pulse_in = 1'b1;
        repeat (n) tick();
        pulse_in = 1'b0;
        tick();
    endtask

    task automatic wait_bytes(input int k, input int budget);
        for (int i = 0; i < budget && rx.size() < k; i++) tick();
    endtask

    function automatic logic [7:0] rb(input int i);
        return (i < rx.size()) ? rx[i] : 8'hxx;
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        pulse_in = 1'b0;
        done_in = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        rx.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b0;
        pulse_in = 1'b0;
        done_in = 1'b0;
        tx_ready = 1'b0;
        #3 reset = 1'b0;
        #1;
        n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, need 0", tx_valid); end
        n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h, need 00", tx_data); end
        n_cmp++; if (pulse_count !== 16'h0) begin n_err++; $display("FAIL reset_count: got %h, need 0", pulse_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b, need 0", overflow); end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        enable = 1'b1;
        tx_ready = 1'b1;
        rx.delete();
        pulse_in = 1'b1;
        repeat (5) tick();
        pulse_in = 1'b0;
        tick();
        n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL lat_write_edge: valid %b, need 0", tx_valid); end
        tick();
        n_cmp++; if (tx_valid !== 1'b1) begin n_err++; $display("FAIL lat_valid: valid %b, need 1", tx_valid); end
        n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL lat_hi_byte: got %h, need 00", tx_data); end
        wait_bytes(2, 20);
        n_cmp++; if (rx.size() != 2) begin n_err++; $display("FAIL single_nbytes: got %0d, need 2", rx.size()); end
        n_cmp++; if (rb(0) !== 8'h00) begin n_err++; $display("FAIL single_hi: got %h, need 00", rb(0)); end
        n_cmp++; if (rb(1) !== 8'h05) begin n_err++; $display("FAIL single_lo: got %h, need 05", rb(1)); end
        n_cmp++; if (pulse_count !== 16'd1) begin n_err++; $display("FAIL single_count: got %0d, need 1", pulse_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL single_overflow: got %b, need 0", overflow); end
    endtask

    task automatic test_widths();
        rx.delete();
        pulse(300);
        pulse(1);
        wait_bytes(4, 40);
        n_cmp++; if (rx.size() != 4) begin n_err++; $display("FAIL widths_nbytes: got %0d, need 4", rx.size()); end
        n_cmp++; if ({rb(0), rb(1)} !== 16'h012C) begin n_err++; $display("FAIL width_300: got %h%h, need 012c", rb(0), rb(1)); end
        n_cmp++; if ({rb(2), rb(3)} !== 16'h0001) begin n_err++; $display("FAIL width_1: got %h%h, need 0001", rb(2), rb(3)); end
        n_cmp++; if (pulse_count !== 16'd3) begin n_err++; $display("FAIL widths_count: got %0d, need 3", pulse_count); end
    endtask

    task automatic test_enable();
        int bad;
        do_reset();
        tx_ready = 1'b1;
        enable = 1'b0;
        pulse(4);
        enable = 1'b1;
        pulse_in = 1'b1;
        repeat (3) tick();
        enable = 1'b0;
        tick();
        pulse_in = 1'b0;
        tick();
        enable = 1'b1;
        repeat (10) tick();
        n_cmp++; if (rx.size() != 0) begin n_err++; $display("FAIL enable_discard_bytes: got %0d, need 0", rx.size()); end
        n_cmp++; if (pulse_count !== 16'd0) begin n_err++; $display("FAIL enable_discard_count: got %0d, need 0", pulse_count); end
        pulse(2);
        wait_bytes(2, 20);
        bad = (rx.size() != 2 || rb(0) !== 8'h00 || rb(1) !== 8'h02) ? 1 : 0;
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL enable_resume: got %0d bytes %h %h, need 00 02", rx.size(), rb(0), rb(1)); end
    endtask

    task automatic test_overflow();
        int bad;
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pulse_in = 1'b1;
            repeat (3) tick();
            pulse_in = 1'b0;
            repeat (2) tick();
        end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b, need 1", overflow); end
        n_cmp++; if (pulse_count !== 16'd9) begin n_err++; $display("FAIL ovf_count: got %0d, need 9", pulse_count); end
        n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin n_err++; $display("FAIL ovf_hold: valid %b data %h, need 1 00", tx_valid, tx_data); end
        tx_ready = 1'b1;
        wait_bytes(18, 80);
        repeat (10) tick();
        n_cmp++; if (rx.size() != 18) begin n_err++; $display("FAIL ovf_nbytes: got %0d, need 18", rx.size()); end
        bad = 0;
        for (int i = 0; i < 18; i++) if (rb(i) !== ((i % 2) ? 8'h03 : 8'h00)) bad++;
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL ovf_bytes: %0d wrong bytes, need 0", bad); end
    endtask

    task automatic test_saturate();
        do_reset();
        tx_ready = 1'b1;
        pulse(70000);
        wait_bytes(2, 20);
        n_cmp++; if (rx.size() != 2) begin n_err++; $display("FAIL sat_nbytes: got %0d, need 2", rx.size()); end
        n_cmp++; if ({rb(0), rb(1)} !== 16'hFFFE) begin n_err++; $display("FAIL sat_word: got %h%h, need fffe", rb(0), rb(1)); end
    endtask

    task automatic test_trailer();
        logic [7:0] exp_b [8];
        exp_b = '{8'h00, 8'h02, 8'h00, 8'h04, 8'h00, 8'h06, 8'hFF, 8'hFF};
        do_reset();
        tx_ready = 1'b0;
        fork
            begin
                pulse(2);
                pulse(4);
                pulse(6);
                done_in = 1'b1;
                tick();
                done_in = 1'b0;
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    tx_ready = ~tx_ready;
                    tick();
                end
            end
        join
        tx_ready = 1'b1;
        repeat (20) tick();
        n_cmp++; if (rx.size() != 8) begin n_err++; $display("FAIL trl_nbytes: got %0d, need 8", rx.size()); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (rb(i) !== exp_b[i]) begin n_err++; $display("FAIL trl_byte%0d: got %h, need %h", i, rb(i), exp_b[i]); end
        end
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        repeat (20) tick();
        n_cmp++; if (rx.size() != 8) begin n_err++; $display("FAIL trl_once: got %0d bytes, need 8", rx.size()); end
        pulse(3);
        repeat (10) tick();
        n_cmp++; if (rx.size() != 8) begin n_err++; $display("FAIL finished_silent: got %0d bytes, need 8", rx.size()); end
        n_cmp++; if (pulse_count !== 16'd4) begin n_err++; $display("FAIL finished_count: got %0d, need 4", pulse_count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tx_ready = 1'b0;
        pulse(5);
        repeat (2) tick();
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        tick();
        n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'h05) begin n_err++; $display("FAIL mid_send_lo: valid %b data %h, need 1 05", tx_valid, tx_data); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b, need 0", tx_valid); end
        n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL mid_data: got %h, need 00", tx_data); end
        n_cmp++; if (pulse_count !== 16'd0) begin n_err++; $display("FAIL mid_count: got %0d, need 0", pulse_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL mid_overflow: got %b, need 0", overflow); end
        tick();
        reset = 1'b1;
        rx.delete();
        tx_ready = 1'b1;
        repeat (10) tick();
        n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_valid: got %b, need 0", tx_valid); end
        n_cmp++; if (rx.size() != 0) begin n_err++; $display("FAIL post_reset_bytes: got %0d, need 0", rx.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_widths();
        test_enable();
        test_overflow();
        test_saturate();
        test_trailer();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
